// File: rtl/fb_arb_pkg.sv
// fb_arb_pkg: shared state encoding and framebuffer geometry for the framebuffer port arbiter
package fb_arb_pkg;
  typedef enum logic [1:0] {IDLE, CPU_RD, VGA_RD} state_t;
  localparam int PIX_AW = 17;
  localparam int NUM_PIX = 76800;
  localparam int PIX_W = 8;
endpackage

// File: rtl/fb_port_arbiter_pix_fifo.sv
// pix_fifo: sync FIFO (clk, reset, push/din, pop/dout, flush) reporting count and empty; dout is 0 when empty
module pix_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = fb_arb_pkg::PIX_W
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  input  logic                     flush,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign empty = count == '0;
  assign do_pop = pop & ~empty;
  assign do_push = push & (count != (AW+1)'(DEPTH));
  assign dout = empty ? '0 : mem[rp];
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (reset | flush) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + 1'b1;
      if (do_pop) rp <= rp + 1'b1;
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/fb_port_arbiter.sv
// fb_port_arbiter: shares one sync framebuffer RAM (mem_*) between CPU load/store (cpu_*) and VGA pixel prefetch (vga_*)
module fb_port_arbiter #(
  parameter int PIX_AW = fb_arb_pkg::PIX_AW,
  parameter int NUM_PIX = fb_arb_pkg::NUM_PIX,
  parameter int FIFO_DEPTH = 8,
  parameter int LOW_WATER = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [PIX_AW-1:0] cpu_addr,
  input  logic [31:0]       cpu_wdata,
  output logic [31:0]       cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_stall,
  input  logic              vga_frame,
  input  logic              vga_pop,
  output logic [7:0]        vga_pixel,
  output logic              vga_underrun,
  output logic [PIX_AW-1:0] mem_addr,
  output logic              mem_we,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata
);
  import fb_arb_pkg::*;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] LW = CW'(LOW_WATER);
  localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);
  localparam logic [PIX_AW-1:0] LAST = PIX_AW'(NUM_PIX - 1);
  state_t state, state_n;
  logic [PIX_AW-1:0] fetch_addr;
  logic [CW-1:0] count, level;
  logic empty, rd_done, drop, wr_ack, push;
  assign level = count + CW'(state == VGA_RD);
  assign push = state == VGA_RD & ~drop & ~vga_frame;
  assign cpu_ack = wr_ack | rd_done;
  assign cpu_stall = cpu_req & ~cpu_ack;
  // rd_done blocks the still-held request from being re-issued in its ack cycle
  always_comb begin
    state_n = state;
    mem_addr = fetch_addr;
    mem_we = 1'b0;
    mem_wdata = '0;
    wr_ack = 1'b0;
    if (state != IDLE) state_n = IDLE;
    else if (level <= LW) state_n = VGA_RD;
    else if (cpu_req & ~rd_done & cpu_we) begin
      mem_addr = cpu_addr;
      mem_we = 1'b1;
      mem_wdata = cpu_wdata;
      wr_ack = 1'b1;
    end else if (cpu_req & ~rd_done) begin
      mem_addr = cpu_addr;
      state_n = CPU_RD;
    end else if (level < FULL) state_n = VGA_RD;
  end
  // a fetch issued in the same cycle as vga_frame targets the old frame, so drop it on return
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      fetch_addr <= '0;
      rd_done <= 1'b0;
      drop <= 1'b0;
      cpu_rdata <= '0;
      vga_underrun <= 1'b0;
    end else begin
      state <= state_n;
      rd_done <= state == CPU_RD;
      drop <= vga_frame & state == IDLE & state_n == VGA_RD;
      if (state == CPU_RD) cpu_rdata <= mem_rdata;
      if (vga_frame) fetch_addr <= '0;
      else if (push) fetch_addr <= fetch_addr == LAST ? '0 : fetch_addr + 1'b1;
      if (vga_pop & empty) vga_underrun <= 1'b1;
    end
  end
  pix_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(PIX_W)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .din(mem_rdata[PIX_W-1:0]),
    .pop(vga_pop),
    .flush(vga_frame),
    .dout(vga_pixel),
    .count(count),
    .empty(empty)
  );
endmodule

// File: tb/tb_fb_port_arbiter.sv
// tb_fb_port_arbiter: directed self-checking bench for fb_port_arbiter with a behavioural 1-cycle RAM
module tb_fb_port_arbiter;
  localparam int NPIX = 24;
  logic clk = 1'b0;
  logic reset, cpu_req, cpu_we, cpu_ack, cpu_stall, vga_frame, vga_pop, vga_underrun, mem_we;
  logic [16:0] cpu_addr, mem_addr;
  logic [31:0] cpu_wdata, cpu_rdata, mem_wdata, mem_rdata;
  logic [7:0] vga_pixel;
  logic [31:0] wmap [int];
  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  fb_port_arbiter #(.NUM_PIX(NPIX)) dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_stall(cpu_stall),
    .vga_frame(vga_frame), .vga_pop(vga_pop), .vga_pixel(vga_pixel), .vga_underrun(vga_underrun),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] pat(int a);
    return 32'(a) * 32'h9E3779B1;
  endfunction

  function automatic logic [7:0] pix(int a);
    logic [31:0] w;
    w = pat(a);
    return w[7:0];
  endfunction

  always @(posedge clk) begin
    mem_rdata <= wmap.exists(int'(mem_addr)) ? wmap[int'(mem_addr)] : pat(int'(mem_addr));
    if (mem_we) wmap[int'(mem_addr)] = mem_wdata;
  end

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    step();
    step();
    checks++; if (cpu_ack !== 1'b0) $display("FAIL reset_ack: got %b want 0", cpu_ack); else passed++;
    checks++; if (mem_we !== 1'b0) $display("FAIL reset_mem_we: got %b want 0", mem_we); else passed++;
    checks++; if (mem_addr !== 17'd0) $display("FAIL reset_mem_addr: got %h want 0", mem_addr); else passed++;
    checks++; if (cpu_rdata !== 32'd0) $display("FAIL reset_rdata: got %h want 0", cpu_rdata); else passed++;
    checks++; if (vga_pixel !== 8'd0) $display("FAIL reset_pixel: got %h want 0", vga_pixel); else passed++;
    checks++; if (vga_underrun !== 1'b0) $display("FAIL reset_underrun: got %b want 0", vga_underrun); else passed++;
  endtask

  task automatic test_fill;
    bit seen = 0;
    reset = 1'b0;
    repeat (20) begin
      step();
      if (mem_we | cpu_ack) seen = 1;
    end
    checks++; if (seen !== 1'b0) $display("FAIL fill_no_write: got %b want 0", seen); else passed++;
    checks++; if (mem_addr !== 17'd8) $display("FAIL fill_fetch_addr: got %0d want 8", mem_addr); else passed++;
    checks++; if (vga_pixel !== pix(0)) $display("FAIL fill_head: got %h want %h", vga_pixel, pix(0)); else passed++;
    checks++; if (vga_underrun !== 1'b0) $display("FAIL fill_underrun: got %b want 0", vga_underrun); else passed++;
  endtask

  task automatic test_cpu_write;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 17'h100; cpu_wdata = 32'hDEADBEEF;
    #1;
    checks++; if (mem_we !== 1'b1) $display("FAIL wr_mem_we: got %b want 1", mem_we); else passed++;
    checks++; if (mem_addr !== 17'h100) $display("FAIL wr_mem_addr: got %h want 100", mem_addr); else passed++;
    checks++; if (mem_wdata !== 32'hDEADBEEF) $display("FAIL wr_mem_wdata: got %h want deadbeef", mem_wdata); else passed++;
    checks++; if (cpu_ack !== 1'b1) $display("FAIL wr_ack: got %b want 1", cpu_ack); else passed++;
    checks++; if (cpu_stall !== 1'b0) $display("FAIL wr_stall: got %b want 0", cpu_stall); else passed++;
    step();
    cpu_req = 1'b0; cpu_we = 1'b0;
    #1;
    checks++; if (cpu_ack !== 1'b0) $display("FAIL wr_ack_drop: got %b want 0", cpu_ack); else passed++;
    checks++; if (mem_we !== 1'b0) $display("FAIL wr_we_drop: got %b want 0", mem_we); else passed++;
  endtask

  task automatic test_back_to_back;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 17'h101; cpu_wdata = 32'h11111111;
    #1;
    checks++; if (cpu_ack !== 1'b1) $display("FAIL b2b_ack0: got %b want 1", cpu_ack); else passed++;
    step();
    cpu_addr = 17'h102; cpu_wdata = 32'h22222222;
    #1;
    checks++; if (cpu_ack !== 1'b1) $display("FAIL b2b_ack1: got %b want 1", cpu_ack); else passed++;
    checks++; if (mem_addr !== 17'h102) $display("FAIL b2b_addr1: got %h want 102", mem_addr); else passed++;
    step();
    cpu_req = 1'b0; cpu_we = 1'b0;
    #1;
  endtask

  task automatic test_cpu_read(input logic [16:0] a, input logic [31:0] exp);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a;
    #1;
    checks++; if (mem_addr !== a) $display("FAIL rd_issue_addr: got %h want %h", mem_addr, a); else passed++;
    checks++; if (cpu_stall !== 1'b1) $display("FAIL rd_stall0: got %b want 1", cpu_stall); else passed++;
    step();
    checks++; if (cpu_ack !== 1'b0) $display("FAIL rd_ack_early: got %b want 0", cpu_ack); else passed++;
    step();
    checks++; if (cpu_ack !== 1'b1) $display("FAIL rd_ack: got %b want 1", cpu_ack); else passed++;
    checks++; if (cpu_rdata !== exp) $display("FAIL rd_data: got %h want %h", cpu_rdata, exp); else passed++;
    step();
    cpu_req = 1'b0;
    #1;
    checks++; if (cpu_ack !== 1'b0) $display("FAIL rd_ack_once: got %b want 0", cpu_ack); else passed++;
  endtask

  task automatic test_contention;
    int ei = 0;
    int acks = 0;
    int bad_pix = 0;
    bit bad_rd = 0;
    bit seen_we = 0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 17'h100;
    for (int k = 0; k < 240; k++) begin
      vga_pop = (k % 4) == 0;
      #1;
      if (vga_pop) begin
        checks++;
        if (vga_pixel !== pix(ei)) begin
          bad_pix++;
          if (bad_pix < 4) $display("FAIL cont_pixel[%0d]: got %h want %h", ei, vga_pixel, pix(ei));
        end else passed++;
        ei = (ei + 1) % NPIX;
      end
      if (cpu_ack) begin
        acks++;
        if (cpu_rdata !== 32'hDEADBEEF) bad_rd = 1;
      end
      if (mem_we) seen_we = 1;
      @(posedge clk);
      #1;
    end
    vga_pop = 1'b0; cpu_req = 1'b0;
    checks++; if (vga_underrun !== 1'b0) $display("FAIL cont_underrun: got %b want 0", vga_underrun); else passed++;
    checks++; if (acks < 10) $display("FAIL cont_cpu_progress: got %0d acks want >=10", acks); else passed++;
    checks++; if (bad_rd !== 1'b0) $display("FAIL cont_rdata: got %b bad reads want 0", bad_rd); else passed++;
    checks++; if (seen_we !== 1'b0) $display("FAIL cont_we: got %b want 0", seen_we); else passed++;
  endtask

  task automatic test_frame;
    repeat (24) step();
    vga_pop = 1'b1;
    step();
    vga_pop = 1'b0;
    step();
    vga_frame = 1'b1;
    step();
    vga_frame = 1'b0;
    #1;
    checks++; if (vga_pixel !== 8'd0) $display("FAIL frame_flush: got %h want 0", vga_pixel); else passed++;
    checks++; if (mem_addr !== 17'd0) $display("FAIL frame_fetch0: got %0d want 0", mem_addr); else passed++;
    step();
    step();
    checks++; if (vga_pixel !== pix(0)) $display("FAIL frame_head: got %h want %h", vga_pixel, pix(0)); else passed++;
    checks++; if (mem_addr !== 17'd1) $display("FAIL frame_fetch1: got %0d want 1", mem_addr); else passed++;
    vga_frame = 1'b1;
    step();
    vga_frame = 1'b0;
    #1;
    checks++; if (vga_pixel !== 8'd0) $display("FAIL frame2_flush: got %h want 0", vga_pixel); else passed++;
    step();
    checks++; if (vga_pixel !== 8'd0) $display("FAIL frame2_drop: got %h want 0", vga_pixel); else passed++;
    checks++; if (mem_addr !== 17'd0) $display("FAIL frame2_fetch0: got %0d want 0", mem_addr); else passed++;
    step();
    step();
    checks++; if (vga_pixel !== pix(0)) $display("FAIL frame2_head: got %h want %h", vga_pixel, pix(0)); else passed++;
  endtask

  task automatic test_underrun;
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
    vga_pop = 1'b1;
    #1;
    checks++; if (vga_pixel !== 8'd0) $display("FAIL urun_pixel: got %h want 0", vga_pixel); else passed++;
    step();
    vga_pop = 1'b0;
    #1;
    checks++; if (vga_underrun !== 1'b1) $display("FAIL urun_set: got %b want 1", vga_underrun); else passed++;
    repeat (20) step();
    checks++; if (vga_underrun !== 1'b1) $display("FAIL urun_sticky: got %b want 1", vga_underrun); else passed++;
    checks++; if (vga_pixel !== pix(0)) $display("FAIL urun_head: got %h want %h", vga_pixel, pix(0)); else passed++;
    reset = 1'b1;
    step();
    checks++; if (vga_underrun !== 1'b0) $display("FAIL urun_clear: got %b want 0", vga_underrun); else passed++;
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    vga_frame = 1'b0; vga_pop = 1'b0;
    test_reset();
    test_fill();
    test_cpu_write();
    test_back_to_back();
    test_cpu_read(17'h100, 32'hDEADBEEF);
    test_cpu_read(17'h102, 32'h22222222);
    test_contention();
    test_frame();
    test_underrun();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
